gray_counter_n: RTL and testbench
=================================

// Module: gray_counter_n
// PURPOSE
//  Parametrised binary/Gray up-down counter; next generation of the 3-bit
//  binary-to-Gray converter, made sequential and width-generic.
//  - Holds a binary count; presents registered binary and Gray views on the same edge.
//  - Supports enable, direction, parallel load of a Gray value (Gray->binary on load),
//    wrap or saturate at the ends, and a terminal-count flag.
//  - Used as a pointer/sequence source where single-bit-change outputs are required.
// PARAMETERS
//  WIDTH  3  counter width in bits (>=2)
//  WRAP   1  1: wrap around at the ends; 0: saturate (hold) at the ends
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      count enable (one step per clk when high)
//  up         in   1      direction: 1 = increment, 0 = decrement
//  load       in   1      synchronous load strobe; overrides en
//  load_gray  in   WIDTH  Gray-coded value to load
//  bin        out  WIDTH  registered binary count
//  gray       out  WIDTH  registered Gray code of bin: bin ^ (bin >> 1)
//  tc         out  1      registered terminal-count flag
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous, any time): bin=0, gray=0, tc=0.
//    Held while rst_n low; first count on first clk edge after release.
//    Reset mid-count abandons the count; no recovery of the prior value.
//  - All updates on the rising clk edge; bin, gray, tc change together (latency 1).
//    gray always equals bin ^ (bin >> 1); never a cycle of mismatch.
//  - Priority per edge: load > en > hold.
//  - load=1: bin <= g2b(load_gray), with g2b[WIDTH-1] = load_gray[WIDTH-1] and
//    g2b[i] = g2b[i+1] ^ load_gray[i]; gray <= load_gray; tc <= 0. en/up ignored.
//  - en=1, load=0, up=1: bin < MAX (2^WIDTH-1) -> bin+1.
//    bin == MAX -> 0 if WRAP=1, stays MAX if WRAP=0.
//  - en=1, load=0, up=0: bin > 0 -> bin-1.
//    bin == 0 -> MAX if WRAP=1, stays 0 if WRAP=0.
//  - tc <= en & ~load & terminal, where terminal = (up ? bin==MAX : bin==0)
//    evaluated on current bin. tc pulses one cycle per wrap.
//    In saturate mode tc stays high each cycle en is held at the terminal value.
//  - en=0, load=0: bin, gray hold; tc <= 0.
//  - up may change on any cycle; new direction applies from that edge.
//    Reversal at a terminal value follows the rules above (e.g. bin=MAX, up=0 -> MAX-1, tc=0).
//  - Arithmetic modulo 2^WIDTH; no X propagation from unused bits; no internal state
//    beyond bin and tc (gray may be a separate register or derived from bin, but is registered).
//  - Every enabled non-saturating step changes exactly one gray bit, including wrap.
// TESTING
//  1 WIDTH=3, reset, en=1 up=1 for 9 clks -> gray 000,001,011,010,110,111,101,100,000.
//    tc high only in the cycle gray returns to 000.
//  2 WIDTH=3, from bin=0, en=1 up=0 for 3 clks -> bin 7,6,5; gray 100,101,111;
//    tc high only in the cycle after leaving 0.
//  3 load=1 load_gray=3'b110 with en=1 -> next cycle bin=3'b100, gray=3'b110, tc=0.
//    Then one up step -> gray=3'b111.
//  4 WRAP=0, WIDTH=3, count up from 6 with en held -> bin 7,7,7; tc=0,1,1.
//    Then up=0 -> bin 6, tc=0.
//  5 Counting at bin=5, drop rst_n between clk edges -> bin/gray/tc 0 immediately.
//    After release, next up step -> bin=1.
//  6 WIDTH=8, random en/up/load for 5000 clks vs reference model.
//    Gray checks: gray==bin^(bin>>1) every cycle; Hamming distance 1 on every enabled
//    non-saturating step.

Source files
------------

// File: rtl/gray_counter_n.sv
// Width-generic binary/Gray up-down counter.
// Registered binary, Gray and terminal-count views.
module gray_counter_n #(
  parameter int WIDTH = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             tc_nxt;
  logic             at_term;

  // Gray to binary: each bit is the parity of itself and all higher bits
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(load_gray >> i);
    end
  end

  // Next count: load beats enable; saturate or wrap at the ends
  always_comb begin
    at_term = up ? (bin == MAX) : (bin == '0);
    bin_nxt = bin;
    tc_nxt  = 1'b0;
    unique case (1'b1)
      load: begin
        bin_nxt = load_bin;
      end
      (en && !load): begin
        tc_nxt = at_term;
        if (at_term && !WRAP) begin
          bin_nxt = bin;
        end else if (up) begin
          bin_nxt = bin + 1'b1;
        end else begin
          bin_nxt = bin - 1'b1;
        end
      end
      default: begin
        bin_nxt = bin;
      end
    endcase
    gray_nxt = bin_nxt ^ (bin_nxt >> 1);
  end

  // All three views move together on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
      tc   <= 1'b0;
    end else begin
      bin  <= bin_nxt;
      gray <= gray_nxt;
      tc   <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: vector table, corner
// sequences and randomized 8-bit run vs model.
module tb_gray_counter_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       en3 = 0, up3 = 0, ld3 = 0;
  logic [2:0] lg3 = '0;
  logic [2:0] b3w, g3w, b3s, g3s;
  logic       t3w, t3s;

  logic       en8 = 0, up8 = 0, ld8 = 0;
  logic [7:0] lg8 = '0;
  logic [7:0] b8w, g8w, b8s, g8s;
  logic       t8w, t8s;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(3), .WRAP(1'b1)) u_w3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .up(up3),
    .load(ld3), .load_gray(lg3),
    .bin(b3w), .gray(g3w), .tc(t3w)
  );

  gray_counter_n #(.WIDTH(3), .WRAP(1'b0)) u_s3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .up(up3),
    .load(ld3), .load_gray(lg3),
    .bin(b3s), .gray(g3s), .tc(t3s)
  );

  gray_counter_n #(.WIDTH(8), .WRAP(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .up(up8),
    .load(ld8), .load_gray(lg8),
    .bin(b8w), .gray(g8w), .tc(t8w)
  );

  gray_counter_n #(.WIDTH(8), .WRAP(1'b0)) u_s8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .up(up8),
    .load(ld8), .load_gray(lg8),
    .bin(b8s), .gray(g8s), .tc(t8s)
  );

  typedef struct {
    bit       en;
    bit       up;
    bit       ld;
    bit [2:0] lg;
    bit [2:0] bin;
    bit [2:0] gray;
    bit       tc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv3(input bit e, input bit u,
                      input bit l, input bit [2:0] g);
    en3 = e;
    up3 = u;
    ld3 = l;
    lg3 = g;
  endtask

  function automatic vec_t mk(input bit e, input bit u,
                              input bit l, input bit [2:0] g,
                              input bit [2:0] b,
                              input bit [2:0] gr,
                              input bit t);
    vec_t v;
    v.en = e; v.up = u; v.ld = l; v.lg = g;
    v.bin = b; v.gray = gr; v.tc = t;
    return v;
  endfunction

  function automatic int g2b8(input int g);
    int b = 0;
    for (int k = 0; k < 8; k++) b = b ^ (g >> k);
    return b & 255;
  endfunction

  function automatic int popc(input logic [7:0] x);
    int c = 0;
    for (int k = 0; k < 8; k++) c += int'(x[k]);
    return c;
  endfunction

  initial begin
    int mw, ms, nw, ns;
    bit tw, ts, moved_w, moved_s;
    logic [7:0] pgw, pgs;

    // up 9 clocks from reset
    tbl.push_back(mk(1, 1, 0, 0, 1, 3'b001, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 3'b011, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3, 3'b010, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4, 3'b110, 0));
    tbl.push_back(mk(1, 1, 0, 0, 5, 3'b111, 0));
    tbl.push_back(mk(1, 1, 0, 0, 6, 3'b101, 0));
    tbl.push_back(mk(1, 1, 0, 0, 7, 3'b100, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 3'b000, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 3'b001, 0));
    // load 0 with en high, then down 3
    tbl.push_back(mk(1, 1, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 7, 3'b100, 1));
    tbl.push_back(mk(1, 0, 0, 0, 6, 3'b101, 0));
    tbl.push_back(mk(1, 0, 0, 0, 5, 3'b111, 0));
    // load 110 overrides en, then one up step
    tbl.push_back(mk(1, 0, 1, 3'b110, 4, 3'b110, 0));
    tbl.push_back(mk(1, 1, 0, 0, 5, 3'b111, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5, 3'b111, 0));
    // reversal at MAX
    tbl.push_back(mk(0, 0, 1, 3'b100, 7, 3'b100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 6, 3'b101, 0));
    // idle at a terminal value gives no tc
    tbl.push_back(mk(0, 0, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0));

    // reset state
    #12;
    chk("rst_bin", 32'(b3w), 0);
    chk("rst_gray", 32'(g3w), 0);
    chk("rst_tc", 32'(t3w), 0);
    chk("rst_bin8", 32'(b8w), 0);
    chk("rst_tc8", 32'(t8s), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drv3(tbl[i].en, tbl[i].up, tbl[i].ld, tbl[i].lg);
      step();
      chk($sformatf("tbl%0d_bin", i), 32'(b3w),
          32'(tbl[i].bin));
      chk($sformatf("tbl%0d_gray", i), 32'(g3w),
          32'(tbl[i].gray));
      chk($sformatf("tbl%0d_tc", i), 32'(t3w),
          32'(tbl[i].tc));
    end

    // saturating counter: up from 6 with en held
    drv3(0, 1, 1, 3'b101);
    step();
    chk("sat_load6", 32'(b3s), 6);
    drv3(1, 1, 0, 0);
    step();
    chk("sat_b0", 32'(b3s), 7);
    chk("sat_t0", 32'(t3s), 0);
    step();
    chk("sat_b1", 32'(b3s), 7);
    chk("sat_t1", 32'(t3s), 1);
    step();
    chk("sat_b2", 32'(b3s), 7);
    chk("sat_t2", 32'(t3s), 1);
    chk("sat_g2", 32'(g3s), 32'(3'b100));
    drv3(1, 0, 0, 0);
    step();
    chk("sat_dn_b", 32'(b3s), 6);
    chk("sat_dn_t", 32'(t3s), 0);
    // saturate at zero going down
    drv3(0, 0, 1, 3'b000);
    step();
    drv3(1, 0, 0, 0);
    step();
    chk("sat0_b", 32'(b3s), 0);
    chk("sat0_t", 32'(t3s), 1);

    // asynchronous reset mid-count
    drv3(0, 1, 1, 3'b111);
    step();
    chk("pre_rst_b", 32'(b3w), 5);
    drv3(1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_b", 32'(b3w), 0);
    chk("arst_g", 32'(g3w), 0);
    chk("arst_t", 32'(t3w), 0);
    #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_b", 32'(b3w), 1);
    chk("post_rst_g", 32'(g3w), 1);
    drv3(0, 0, 0, 0);

    // randomized 8-bit run against integer model
    mw = 0;
    ms = 0;
    for (int c = 0; c < 5000; c++) begin
      en8 = ($urandom_range(0, 9) < 7);
      up8 = $urandom_range(0, 1) != 0;
      ld8 = ($urandom_range(0, 19) == 0);
      lg8 = 8'($urandom_range(0, 255));
      pgw = g8w;
      pgs = g8s;
      moved_w = 0;
      moved_s = 0;
      tw = 0;
      ts = 0;
      if (ld8) begin
        mw = g2b8(int'(lg8));
        ms = mw;
      end else if (en8) begin
        nw = mw + (up8 ? 1 : -1);
        ns = ms + (up8 ? 1 : -1);
        tw = (nw < 0) || (nw > 255);
        ts = (ns < 0) || (ns > 255);
        mw = (nw + 256) % 256;
        moved_w = 1;
        if (!ts) begin
          ms = ns;
          moved_s = 1;
        end
      end
      step();
      chk("rnd_w_bin", 32'(b8w), 32'(mw));
      chk("rnd_w_gray", 32'(g8w), 32'(mw ^ (mw >> 1)));
      chk("rnd_w_tc", 32'(t8w), 32'(tw));
      chk("rnd_s_bin", 32'(b8s), 32'(ms));
      chk("rnd_s_gray", 32'(g8s), 32'(ms ^ (ms >> 1)));
      chk("rnd_s_tc", 32'(t8s), 32'(ts));
      if (moved_w) begin
        chk("rnd_w_ham", 32'(popc(g8w ^ pgw)), 1);
      end
      if (moved_s) begin
        chk("rnd_s_ham", 32'(popc(g8s ^ pgs)), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
